// File: rtl/wb_master_lsu.sv
// Load/store unit to Wishbone classic initiator: one request at a time, size-coded select, extended load data.
// Optional ack timeout is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_lsu #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = WB_DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_signed_i,
  input  logic [WB_DATA_WIDTH-1:0] req_data_i,
  output logic                     rsp_valid_o,
  output logic [WB_DATA_WIDTH-1:0] rsp_data_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_ack_i
);

  if (WB_DATA_WIDTH != 32) begin : g_bad_width
    $error("wb_master_lsu supports only a 32-bit data bus");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [WB_SEL_WIDTH-1:0] SEL_BYTE = WB_SEL_WIDTH'(1);
  localparam logic [WB_SEL_WIDTH-1:0] SEL_HALF = WB_SEL_WIDTH'(3);
  localparam logic [WB_SEL_WIDTH-1:0] SEL_WORD = '1;

  state_t                   state_q, state_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q;
  logic [WB_DATA_WIDTH-1:0] data_q;
  logic [1:0]               size_q;
  logic                     we_q;
  logic                     signed_q;
  logic [WB_DATA_WIDTH-1:0] rsp_data_q;
  logic                     rsp_err_q;
  logic                     req_bad;
  logic                     timeout_hit;
  logic [WB_DATA_WIDTH-1:0] load_ext;

  // Size 11 and misaligned half/word requests never reach the bus.
  always_comb begin
    req_bad = 1'b0;
    case (req_size_i)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr_i[0];
      2'b10:   req_bad = (req_addr_i[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    load_ext = wb_data_i;
    case (size_q)
      2'b00:   load_ext = {{(WB_DATA_WIDTH-8){signed_q & wb_data_i[7]}}, wb_data_i[7:0]};
      2'b01:   load_ext = {{(WB_DATA_WIDTH-16){signed_q & wb_data_i[15]}}, wb_data_i[15:0]};
      default: load_ext = wb_data_i;
    endcase
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_q != S_BUS) begin
      tmo_cnt_q <= '0;
    end else if (!wb_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  // Ack on the terminal-count cycle still completes normally.
  assign timeout_hit = (state_q == S_BUS) && !wb_ack_i && (tmo_cnt_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_data_o  = '0;
    rsp_err_o   = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_addr_o   = '0;
    wb_data_o   = '0;
    wb_sel_o    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = req_bad ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        wb_cyc_o  = 1'b1;
        wb_stb_o  = 1'b1;
        wb_we_o   = we_q;
        wb_addr_o = addr_q;
        wb_data_o = data_q;
        case (size_q)
          2'b00:   wb_sel_o = SEL_BYTE;
          2'b01:   wb_sel_o = SEL_HALF;
          default: wb_sel_o = SEL_WORD;
        endcase
        if (wb_ack_i || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = rsp_data_q;
        rsp_err_o   = rsp_err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and response formation; slave data is only valid in the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q     <= req_addr_i;
            data_q     <= req_data_i;
            size_q     <= req_size_i;
            we_q       <= req_we_i;
            signed_q   <= req_signed_i;
            rsp_data_q <= '0;
            rsp_err_q  <= req_bad;
          end
        end
        S_BUS: begin
          if (wb_ack_i) begin
            rsp_data_q <= we_q ? '0 : load_ext;
            rsp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_lsu.sv
// Directed bench for wb_master_lsu with a byte-array RAM slave (ack 1 cycle, 2 for sub-word writes).
// Build with WB_MASTER_TIMEOUT_EN defined to exercise the timeout path.
module tb_wb_master_lsu;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [31:0] wb_rdata;
  logic        wb_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:255];
  bit         ack_en = 1'b1;
  int         ack_cnt = 0;

  always #5 clk = ~clk;

  wb_master_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_size_i(req_size), .req_signed_i(req_signed), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .wb_addr_o(wb_addr), .wb_data_o(wb_wdata), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_data_i(wb_rdata), .wb_ack_i(wb_ack)
  );

  // Slave returns the full little-endian word at the byte address; upper lanes carry neighbour bytes.
  always_comb begin
    logic [7:0] a;
    a = wb_addr[7:0];
    wb_rdata = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  end

  always @(posedge clk) begin
    int need;
    need = (wb_we && wb_sel != 4'hF) ? 2 : 1;
    if (wb_cyc && wb_stb && wb_ack && wb_we) begin
      mem[wb_addr[7:0]] <= wb_wdata[7:0];
      if (wb_sel[1]) mem[wb_addr[7:0] + 8'd1] <= wb_wdata[15:8];
      if (wb_sel[2]) mem[wb_addr[7:0] + 8'd2] <= wb_wdata[23:16];
      if (wb_sel[3]) mem[wb_addr[7:0] + 8'd3] <= wb_wdata[31:24];
    end
    if (wb_cyc && wb_stb && !wb_ack && ack_en) begin
      if (ack_cnt + 1 >= need) begin
        wb_ack  <= 1'b1;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      wb_ack  <= 1'b0;
      ack_cnt <= 0;
    end
  end

  // Issues one request and watches it to the response (bounded).
  task automatic run_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] data,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int cycn, output logic [3:0] sel0, output logic [31:0] addr0,
                         output logic [31:0] data0, output logic stable, output logic got);
    @(negedge clk);
    req_addr = addr; req_we = we; req_size = size; req_signed = sgn; req_data = data;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; cycn = 0; stable = 1'b1; got = 1'b0; rdata = '0; err = 1'b0;
    sel0 = '0; addr0 = '0; data0 = '0;
    while (!got && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (wb_cyc) begin
        if (cycn == 0) begin
          sel0 = wb_sel; addr0 = wb_addr; data0 = wb_wdata;
        end else if (wb_sel !== sel0 || wb_addr !== addr0 || wb_wdata !== data0) begin
          stable = 1'b0;
        end
        cycn++;
      end
      if (rsp_valid) begin
        got = 1'b1; rdata = rsp_data; err = rsp_err;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 00000", {rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we});
    end
    n_cmp++; if ({rsp_data, wb_addr, wb_wdata, wb_sel} !== 100'b0) begin
      n_bad++; $display("FAIL reset_buses got %h %h %h %h want 0", rsp_data, wb_addr, wb_wdata, wb_sel);
    end
  endtask

  task automatic test_word;
    int lat, cycn; logic [31:0] rd, a0, d0; logic err, st, got; logic [3:0] s0;
    run_req(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || lat != 3) begin n_bad++; $display("FAIL word_st_latency got %0d want 3", lat); end
    n_cmp++; if (s0 !== 4'hF || d0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_st_bus got sel %h data %h want f deadbeef", s0, d0); end
    n_cmp++; if (rd !== 32'h0 || err !== 1'b0) begin n_bad++; $display("FAIL word_st_rsp got %h err %b want 0 0", rd, err); end
    run_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || lat != 3) begin n_bad++; $display("FAIL word_ld_latency got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF || err !== 1'b0 || s0 !== 4'hF) begin
      n_bad++; $display("FAIL word_ld_rsp got %h err %b sel %h want deadbeef 0 f", rd, err, s0);
    end
  endtask

  task automatic test_byte;
    int lat, cycn; logic [31:0] rd, a0, d0; logic err, st, got; logic [3:0] s0;
    run_req(32'h13, 1'b1, 2'b00, 1'b0, 32'h80, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || lat != 4 || cycn != 3) begin n_bad++; $display("FAIL byte_st_timing got lat %0d cyc %0d want 4 3", lat, cycn); end
    n_cmp++; if (s0 !== 4'h1 || a0 !== 32'h13 || d0 !== 32'h80 || st !== 1'b1) begin
      n_bad++; $display("FAIL byte_st_bus got sel %h addr %h data %h stable %b want 1 13 80 1", s0, a0, d0, st);
    end
    run_req(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || rd !== 32'hFFFFFF80 || err !== 1'b0) begin n_bad++; $display("FAIL byte_ld_signed got %h want ffffff80", rd); end
    run_req(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || rd !== 32'h00000080) begin n_bad++; $display("FAIL byte_ld_unsigned got %h want 00000080", rd); end
    run_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || rd !== 32'h80ADBEEF) begin n_bad++; $display("FAIL byte_word_merge got %h want 80adbeef", rd); end
  endtask

  task automatic test_misaligned;
    int lat, cycn; logic [31:0] rd, a0, d0; logic err, st, got; logic [3:0] s0;
    run_req(32'h11, 1'b0, 2'b01, 1'b1, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || lat != 1 || err !== 1'b1 || rd !== 32'h0 || cycn != 0) begin
      n_bad++; $display("FAIL misalign_half got lat %0d err %b data %h cyc %0d want 1 1 0 0", lat, err, rd, cycn);
    end
    run_req(32'h10, 1'b0, 2'b11, 1'b0, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || lat != 1 || err !== 1'b1 || rd !== 32'h0 || cycn != 0) begin
      n_bad++; $display("FAIL illegal_size got lat %0d err %b data %h cyc %0d want 1 1 0 0", lat, err, rd, cycn);
    end
    run_req(32'h12, 1'b1, 2'b10, 1'b0, 32'h12345678, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || err !== 1'b1 || cycn != 0) begin
      n_bad++; $display("FAIL misalign_word got err %b cyc %0d want 1 0", err, cycn);
    end
  endtask

  task automatic test_back_to_back;
    int accepts, cyc, rsps;
    logic [31:0] rd;
    logic err;
    int lat, cycn; logic [31:0] a0, d0; logic st, got; logic [3:0] s0;
    @(negedge clk);
    req_addr = 32'h12; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_data = 32'h8001;
    req_valid = 1'b1;
    accepts = 0; rsps = 0; rd = '0; err = 1'b0; cyc = 0;
    while (rsps == 0 && cyc < 50) begin
      if (req_valid && req_ready) accepts++;
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin rsps++; err = rsp_err; rd = rsp_data; req_valid = 1'b0; end
    end
    @(negedge clk);
    n_cmp++; if (accepts != 1 || rsps != 1) begin n_bad++; $display("FAIL hold_valid_accepts got %0d/%0d want 1/1", accepts, rsps); end
    n_cmp++; if (cyc != 4 || err !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL half_st_rsp got lat %0d err %b data %h want 4 0 0", cyc, err, rd); end
    run_req(32'h12, 1'b0, 2'b01, 1'b1, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || rd !== 32'hFFFF8001 || s0 !== 4'h3) begin
      n_bad++; $display("FAIL half_ld_signed got %h sel %h want ffff8001 3", rd, s0);
    end
  endtask

  task automatic test_timeout;
    ack_en = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    begin
      int lat, cycn; logic [31:0] rd, a0, d0; logic err, st, got; logic [3:0] s0;
      run_req(32'h20, 1'b0, 2'b10, 1'b0, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
      n_cmp++; if (got !== 1'b1 || cycn != 4 || lat != 5) begin n_bad++; $display("FAIL timeout_timing got cyc %0d lat %0d want 4 5", cycn, lat); end
      n_cmp++; if (err !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL timeout_rsp got err %b data %h want 1 0", err, rd); end
    end
`else
    begin
      int low_or_rsp;
      @(negedge clk);
      req_addr = 32'h20; req_we = 1'b0; req_size = 2'b10; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      low_or_rsp = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (!wb_cyc || !wb_stb || rsp_valid) low_or_rsp++;
      end
      n_cmp++; if (low_or_rsp != 0) begin n_bad++; $display("FAIL no_timeout_hold got %0d bad cycles want 0", low_or_rsp); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
    end
`endif
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_bus;
    int stray;
    int lat, cycn; logic [31:0] rd, a0, d0; logic err, st, got; logic [3:0] s0;
    ack_en = 1'b0;
    @(negedge clk);
    req_addr = 32'h10; req_we = 1'b0; req_size = 2'b10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (wb_cyc !== 1'b1) begin n_bad++; $display("FAIL rst_bus_precond got cyc %b want 1", wb_cyc); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({wb_cyc, wb_stb, req_ready, rsp_valid} !== 4'b0010) begin
      n_bad++; $display("FAIL rst_mid_bus got cyc/stb/ready/rsp %b want 0010", {wb_cyc, wb_stb, req_ready, rsp_valid});
    end
    rst = 1'b0;
    ack_en = 1'b1;
    stray = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid || wb_cyc) stray++; end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL rst_dropped got %0d stray cycles want 0", stray); end
    run_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, lat, rd, err, cycn, s0, a0, d0, st, got);
    n_cmp++; if (got !== 1'b1 || rd !== 32'h8001BEEF || err !== 1'b0) begin
      n_bad++; $display("FAIL rst_recover got %h err %b want 8001beef 0", rd, err);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    test_reset;
    test_word;
    test_byte;
    test_misaligned;
    test_back_to_back;
    test_timeout;
    test_reset_mid_bus;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_master_lsu.md
# wb_master_lsu

Wishbone initiator bridging the core's load/store unit to the data-side Wishbone bus and RAM slave. Accepts one load/store request at a time over a valid/ready handshake, checks alignment, runs a single Wishbone classic cycle using the codebase's size-coded select convention, waits for ack, and returns sign- or zero-extended load data (or an error) as a one-cycle response pulse. Optional ack timeout turns a hung bus into a reportable error.

## Interface
- WB_DATA_WIDTH, 32, data width; only 32 is supported
- WB_ADDR_WIDTH, 32, address width
- WB_SEL_WIDTH, WB_DATA_WIDTH/8, select width
- TIMEOUT_CYCLES, 255, max cycles in BUS without ack before abort (used only with WB_MASTER_TIMEOUT_EN); 8-bit counter, legal range 1..255
- wb_clk_i  in  1  clock; one clock domain, all logic on rising edge
- wb_rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  request can be accepted (high only in IDLE)
- req_addr_i  in  WB_ADDR_WIDTH  byte address
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed_i  in  1  sign-extend load result
- req_data_i  in  WB_DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_data_o  out  WB_DATA_WIDTH  load result; 0 for stores and errors
- rsp_err_o  out  1  misaligned/illegal size/timeout; valid with rsp_valid_o
- wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o  out  master signals
- wb_data_i, wb_ack_i  in  slave signals

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready_o=1. On req_valid_i: register addr, we, size, signed, data.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11 -> RESP with err=1; no bus cycle.
  - Else -> BUS.
- BUS: cyc=stb=1; wb_addr_o = full registered byte address (low bits untouched; slave does lane steering); wb_sel_o = 0001 byte, 0011 half, 1111 word (size code, not lane mask); wb_data_o = registered data unshifted; wb_we_o = registered we. All held stable until ack.
  - On wb_ack_i: capture wb_data_i in that same cycle (slave output is combinational on addr/sel) -> RESP.
- RESP: cyc=stb=0; rsp_valid_o=1 for exactly this cycle -> IDLE. No backpressure; consumer must take it.
- Load result: byte -> {24{s&d[7]}, d[7:0]}; half -> {16{s&d[15]}, d[15:0]}; word -> d, where s = req_signed_i. Stores: rsp_data_o=0, err=0.
- req_valid_i outside IDLE is ignored (not accepted).

## Timing
- Reset values: req_ready_o=1 (IDLE), rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_addr_o=0, wb_data_o=0.
- Accept at edge N; cyc/stb high from N+1; ack at cycle A samples data; rsp_valid_o high in A+1; req_ready_o high again A+2.
- With the team's RAM: word read/write ack one cycle after stb -> rsp 3 cycles after accept; byte/half write ack two cycles after stb -> rsp 4 cycles after accept.
- Misaligned: rsp_valid_o with err the cycle after accept; cyc never rises.
- cyc/stb fall on the edge following ack; never asserted in RESP, so slave's post-ack idle cycle is honoured.
- Reset mid-BUS: cyc/stb deassert after the reset edge; pending request dropped, no response.

## Configuration
- WB_MASTER_TIMEOUT_EN defined: counter cleared on BUS entry, increments per BUS cycle without ack; when count reaches TIMEOUT_CYCLES with no ack, drop cyc/stb, go RESP with err=1, data=0. Ack in the same cycle as terminal count wins (normal response).
- Undefined: no counter; BUS waits indefinitely for ack; rsp_err_o only from alignment/size.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10 -> sel 1111, rsp_data_o=0xDEADBEEF, err=0, response 3 cycles after accept.
- Byte store 0x80 to 0x13, signed byte load 0x13 -> store sel 0001 held 2 cycles until ack; load returns 0xFFFFFF80; unsigned returns 0x00000080; word load 0x10 returns 0x80ADBEEF.
- Half load 0x11 -> rsp err=1, data=0 next cycle, cyc never high; size 11 same.
- Half store 0x8001 to 0x12, signed half load -> 0xFFFF8001; req_valid_i held high throughout, only one accept per response.
- Timeout (macro on, TIMEOUT_CYCLES=4, slave never acks) -> cyc drops after 4 BUS cycles, err=1; macro off -> cyc stays high 1000 cycles.
- Reset asserted during BUS -> next cycle cyc=stb=0, req_ready_o=1, no rsp_valid_o.
